// File: rtl/shreg_pkg.sv
// Shared constants and state type for the 74194-style shift register sequencer.
package shreg_pkg;
    localparam logic [1:0] OP_LOAD   = 2'd0;
    localparam logic [1:0] OP_SHL    = 2'd1;
    localparam logic [1:0] OP_SHR    = 2'd2;
    localparam logic [1:0] OP_ROL    = 2'd3;

    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_SHL  = 2'd1;
    localparam logic [1:0] MODE_SHR  = 2'd2;
    localparam logic [1:0] MODE_LOAD = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/shreg_sequencer_if.sv
// Command handshake and status bundle between a command source and shreg_sequencer.
interface shreg_sequencer_if #(
    parameter int LENGTH = 4,
    parameter int CNT_W  = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CNT_W-1:0]  cmd_count;
    logic [LENGTH-1:0] cmd_data;
    logic              cmd_fill;
    logic              busy;
    logic              done;

    modport master (output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill,
                    input  cmd_ready, busy, done);
    modport slave  (input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_fill,
                    output cmd_ready, busy, done);
endinterface

// File: rtl/shreg_sequencer.sv
// Drives S1/S0/P/DSR/DSL of a 74194-style register for one command at a time.
// Optional abort/aborted ports are enabled by defining SHREG_SEQ_ABORT_EN.
module shreg_sequencer
    import shreg_pkg::*;
#(
    parameter int LENGTH = 4,
    parameter int CNT_W  = 3
) (
    input  logic              CLOCK,
    input  logic              _MR,
    shreg_sequencer_if.slave  cmd,
    input  logic [LENGTH-1:0] Q_IN,
    output logic              S1,
    output logic              S0,
    output logic [LENGTH-1:0] P,
    output logic              DSR,
    output logic              DSL
`ifdef SHREG_SEQ_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);
    localparam int SEL_W = $clog2(LENGTH);

    state_t            state_q, state_n;
    logic [1:0]        mode_q, mode_n, op_q, op_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [LENGTH-1:0] p_q, p_n;
    logic              dsr_q, dsr_n, dsl_q, dsl_n;
    logic              done_q, ready_q, busy_q;
    logic              abt_q, abt_n, abort_req;
    logic [SEL_W-1:0]  bit_sel;

`ifdef SHREG_SEQ_ABORT_EN
    assign abort_req = abort;
    assign aborted   = abt_q;
`else
    assign abort_req = 1'b0;
`endif

    // Rotate feeds DSR with the MSB the register will hold at the next edge:
    // Q[MSB] when the register is idle, Q[MSB-1] while it is already rotating.
    assign bit_sel = (state_q == IDLE) ? SEL_W'(LENGTH-1) : SEL_W'(LENGTH-2);

    always_comb begin
        state_n = state_q;
        mode_n  = MODE_HOLD;
        op_n    = op_q;
        cnt_n   = cnt_q;
        p_n     = p_q;
        dsr_n   = dsr_q;
        dsl_n   = dsl_q;
        abt_n   = 1'b0;
        case (state_q)
            IDLE: if (cmd.cmd_valid) begin
                op_n = cmd.cmd_op;
                if (cmd.cmd_op == OP_LOAD) begin
                    state_n = RUN;
                    mode_n  = MODE_LOAD;
                    p_n     = cmd.cmd_data;
                    cnt_n   = CNT_W'(1);
                end else if (cmd.cmd_count == '0) begin
                    state_n = DONE;
                end else begin
                    state_n = RUN;
                    cnt_n   = cmd.cmd_count;
                    mode_n  = (cmd.cmd_op == OP_SHR) ? MODE_SHR : MODE_SHL;
                    case (cmd.cmd_op)
                        OP_SHL:  dsr_n = cmd.cmd_fill;
                        OP_SHR:  dsl_n = cmd.cmd_fill;
                        default: dsr_n = Q_IN[bit_sel];
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1) || abort_req) begin
                    state_n = DONE;
                    cnt_n   = '0;
                    abt_n   = abort_req;
                end else begin
                    cnt_n  = cnt_q - CNT_W'(1);
                    mode_n = mode_q;
                    if (op_q == OP_ROL) dsr_n = Q_IN[bit_sel];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge _MR) begin
        if (!_MR) state_q <= IDLE;
        else      state_q <= state_n;
    end

    always_ff @(posedge CLOCK or negedge _MR) begin
        if (!_MR) begin
            mode_q  <= MODE_HOLD;
            op_q    <= OP_LOAD;
            cnt_q   <= '0;
            p_q     <= '0;
            dsr_q   <= 1'b0;
            dsl_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            mode_q  <= mode_n;
            op_q    <= op_n;
            cnt_q   <= cnt_n;
            p_q     <= p_n;
            dsr_q   <= dsr_n;
            dsl_q   <= dsl_n;
            done_q  <= (state_n == DONE);
            ready_q <= (state_n == IDLE);
            busy_q  <= (state_n != IDLE);
            abt_q   <= abt_n;
        end
    end

    assign {S1, S0}      = mode_q;
    assign P             = p_q;
    assign DSR           = dsr_q;
    assign DSL           = dsl_q;
    assign cmd.done      = done_q;
    assign cmd.cmd_ready = ready_q;
    assign cmd.busy      = busy_q;
endmodule

// File: tb/tb_shreg_sequencer.sv
// Directed bench: shreg_sequencer driving a behavioural 74194 register on shared CLOCK/_MR.
module tb_shreg_sequencer;
    import shreg_pkg::*;

    logic       CLOCK = 1'b0;
    logic       _MR;
    logic [3:0] Q_IN;
    logic       S1, S0, DSR, DSL;
    logic [3:0] P;
    int         checks = 0;
    int         errors = 0;
`ifdef SHREG_SEQ_ABORT_EN
    logic       abort, aborted;
`endif

    shreg_sequencer_if #(.LENGTH(4), .CNT_W(3)) cif ();

    shreg_sequencer #(.LENGTH(4), .CNT_W(3)) dut (
        .CLOCK(CLOCK), ._MR(_MR), .cmd(cif), .Q_IN(Q_IN),
        .S1(S1), .S0(S0), .P(P), .DSR(DSR), .DSL(DSL)
`ifdef SHREG_SEQ_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    // Behavioural SN74194: hold / shift-left / shift-right / load
    always_ff @(posedge CLOCK or negedge _MR) begin
        if (!_MR) Q_IN <= 4'b0000;
        else case ({S1, S0})
            2'd1: Q_IN <= {Q_IN[2:0], DSR};
            2'd2: Q_IN <= {DSL, Q_IN[3:1]};
            2'd3: Q_IN <= P;
            default: Q_IN <= Q_IN;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge CLOCK);
        #1;
    endtask

    // Present a command for one edge, then scramble the fields to prove they were latched
    task automatic issue(input logic [1:0] op, input logic [2:0] n, input logic [3:0] d, input logic f);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_count = n;
        cif.cmd_data  = d;
        cif.cmd_fill  = f;
        edge1();
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = ~op;
        cif.cmd_count = ~n;
        cif.cmd_data  = ~d;
        cif.cmd_fill  = ~f;
    endtask

    task automatic load(input logic [3:0] d);
        issue(OP_LOAD, 3'd0, d, 1'b0);
        edge1();
        edge1();
    endtask

    initial begin
        logic [3:0] exp_q [5];
        _MR = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_op = 2'd0;
        cif.cmd_count = 3'd0;
        cif.cmd_data = 4'd0;
        cif.cmd_fill = 1'b0;
`ifdef SHREG_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        chk("rst_mode",  {S1, S0}, 2'd0);
        chk("rst_p",     P, 4'd0);
        chk("rst_ser",   {DSR, DSL}, 2'b00);
        chk("rst_done",  cif.done, 1'b0);
        chk("rst_busy",  cif.busy, 1'b0);
        chk("rst_ready", cif.cmd_ready, 1'b1);
        @(negedge CLOCK);
        _MR = 1'b1;

        // Load 1010
        issue(OP_LOAD, 3'd5, 4'b1010, 1'b0);
        chk("ld_mode",  {S1, S0}, 2'd3);
        chk("ld_p",     P, 4'b1010);
        chk("ld_busy",  {cif.busy, cif.cmd_ready, cif.done}, 3'b100);
        edge1();
        chk("ld_q",     Q_IN, 4'b1010);
        chk("ld_done",  {S1, S0, cif.done, cif.cmd_ready}, 4'b0010);
        edge1();
        chk("ld_idle",  {cif.done, cif.cmd_ready, cif.busy}, 3'b010);

        // Shift left, fill 1, three steps from 0000
        load(4'b0000);
        chk("shl_pre", Q_IN, 4'b0000);
        issue(OP_SHL, 3'd3, 4'd0, 1'b1);
        chk("shl_dsr", DSR, 1'b1);
        exp_q[0] = 4'b0001; exp_q[1] = 4'b0011; exp_q[2] = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("shl_mode%0d", i), {S1, S0}, 2'd1);
            edge1();
            chk($sformatf("shl_q%0d", i), Q_IN, exp_q[i]);
        end
        chk("shl_done", {S1, S0, cif.done}, 3'b001);
        edge1();

        // Rotate left five steps from 1000
        load(4'b1000);
        issue(OP_ROL, 3'd5, 4'd0, 1'b0);
        chk("rol_dsr0", DSR, 1'b1);
        exp_q[0] = 4'b0001; exp_q[1] = 4'b0010; exp_q[2] = 4'b0100;
        exp_q[3] = 4'b1000; exp_q[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rol_mode%0d", i), {S1, S0}, 2'd1);
            edge1();
            chk($sformatf("rol_q%0d", i), Q_IN, exp_q[i]);
        end
        chk("rol_done", {S1, S0, cif.done}, 3'b001);
        edge1();

        // Zero-count shift right; a load held valid during DONE must be ignored
        issue(OP_SHR, 3'd0, 4'd0, 1'b1);
        chk("z_done", {S1, S0, cif.done, cif.busy, cif.cmd_ready}, 5'b00110);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = OP_LOAD;
        cif.cmd_data  = 4'b1111;
        edge1();
        cif.cmd_valid = 1'b0;
        chk("z_ignore", {S1, S0, cif.done, cif.busy, cif.cmd_ready}, 5'b00001);
        chk("z_q", Q_IN, 4'b0001);
        edge1();
        chk("z_q2", Q_IN, 4'b0001);

        // Reset in the middle of a 7-step shift left
        issue(OP_SHL, 3'd7, 4'd0, 1'b1);
        edge1();
        edge1();
        chk("mr_q2", Q_IN, 4'b0111);
        #2;
        _MR = 1'b0;
        #1;
        chk("mr_out", {S1, S0, P, DSR, DSL}, 8'd0);
        chk("mr_stat", {cif.done, cif.busy, cif.cmd_ready}, 3'b001);
        chk("mr_q", Q_IN, 4'b0000);
        edge1();
        chk("mr_nodone", cif.done, 1'b0);
        @(negedge CLOCK);
        _MR = 1'b1;
        load(4'b0101);
        chk("mr_reload", Q_IN, 4'b0101);

`ifdef SHREG_SEQ_ABORT_EN
        // Abort sampled on the second step edge of a 6-step shift right
        load(4'b1111);
        issue(OP_SHR, 3'd6, 4'd0, 1'b0);
        chk("ab_mode", {S1, S0}, 2'd2);
        abort = 1'b1;
        @(negedge CLOCK);
        abort = 1'b0;
        edge1();
        chk("ab_q1", Q_IN, 4'b0111);
        abort = 1'b1;
        edge1();
        abort = 1'b0;
        chk("ab_q2", Q_IN, 4'b0011);
        chk("ab_done", {S1, S0, cif.done, aborted}, 4'b0011);
        edge1();
        chk("ab_end", {Q_IN, cif.done, aborted, cif.cmd_ready}, 7'b0011001);
        abort = 1'b1;
        load(4'b1001);
        abort = 1'b0;
        chk("ab_idle", {Q_IN, aborted}, 5'b10010);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shreg_sequencer.md
Name: shreg_sequencer

Overview:
- Command sequencer that sits directly upstream of the 4-bit universal shift register (SN74194-style: hold / shift-left / shift-right / parallel-load).
- Accepts one command at a time over a valid/ready handshake.
- Drives the register's S1, S0, P, DSR and DSL pins for exactly as many clocks as the command requires, then pulses done.
- Reads the register's Q back so it can perform rotates.

Parameters:
- LENGTH, 4, width of the driven shift register (P, Q).
- CNT_W, 3, width of the shift-count field; at most 2**CNT_W-1 steps per command.

Ports:
- CLOCK  input  1  rising-edge clock, shared with the shift register.
- _MR  input  1  asynchronous active-low reset, shared with the shift register.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  operation: 0 load, 1 shift left, 2 shift right, 3 rotate left.
- cmd_count  input  CNT_W  number of shift/rotate steps; ignored for load.
- cmd_data  input  LENGTH  parallel load value.
- cmd_fill  input  1  serial fill bit for shift left/right.
- Q_IN  input  LENGTH  current Q of the driven register.
- S1, S0  output  1 each  mode select to the register.
- P  output  LENGTH  parallel data to the register.
- DSR, DSL  output  1 each  serial inputs to the register.
- busy  output  1  high in RUN or DONE.
- done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Register mode encoding {S1,S0}:
  - 0 hold.
  - 1 shift left, Q <= {Q[LENGTH-2:0],DSR}.
  - 2 shift right, Q <= {DSL,Q[LENGTH-1:1]}.
  - 3 load P.
- All outputs are registered. States are IDLE, RUN and DONE.
- Reset (_MR=0, any time, including mid-command):
  - State goes to IDLE immediately and the step counter clears.
  - {S1,S0}=0, P=0, DSR=0, DSL=0, done=0, busy=0, cmd_ready=1 after release.
- IDLE:
  - cmd_ready=1 and {S1,S0}=0.
  - A command is accepted on a rising edge with cmd_valid=1. Op, count, data and fill are latched at that edge and may change afterwards.
- Accept, load: the next cycle drives {S1,S0}=3 with P=cmd_data for exactly 1 cycle, then goes to DONE.
- Accept, shift/rotate with count N>0: RUN drives the mode for exactly N cycles, then goes to DONE. The register therefore moves N times, on edges k+1..k+N where k is the accept edge.
  - Shift left: {S1,S0}=1, DSR=fill.
  - Shift right: {S1,S0}=2, DSL=fill.
  - Rotate left: {S1,S0}=1, DSR=Q_IN[LENGTH-1], sampled combinationally each RUN cycle and registered so it is valid before the next edge. The implementation must present the bit the register will hold at that edge.
- Accept with N=0 and op 1–3: goes straight to DONE. {S1,S0} stays 0 and the register is unchanged.
- DONE:
  - Lasts 1 cycle with done=1, {S1,S0}=0, cmd_ready=0; then returns to IDLE.
  - Minimum command-to-command spacing is N+2 cycles (3 for load).
- Outside RUN/load cycles: DSR, DSL and P hold their last values; only S1/S0 gate their effect.
- cmd_valid while busy is ignored; no queueing.
- The step counter is CNT_W bits and counts down from N to 0; no wrap occurs.

Optional Feature:
- Macro: SHREG_SEQ_ABORT_EN.
- Defined: adds an input port `abort` (1 bit).
  - abort=1 sampled during RUN or the load cycle forces {S1,S0}=0 from the next cycle and moves to DONE.
  - done pulses and an extra output `aborted` (1 bit) is high together with done.
  - Steps already taken are not undone.
  - abort in IDLE or DONE has no effect.
- Undefined: no abort/aborted ports; every command runs to completion.

Decomposition:
- Shared package `shreg_pkg`:
  - Op-code constants: OP_LOAD=0, OP_SHL=1, OP_SHR=2, OP_ROL=3.
  - Mode constants: MODE_HOLD=0, MODE_SHL=1, MODE_SHR=2, MODE_LOAD=3.
  - State enum: IDLE, RUN, DONE.
- Single module; no sub-module.
- The top-level bench instantiates shreg_sequencer driving SN74194v2 with shared CLOCK/_MR.

Test Plan:
- Reset then load: _MR pulse, cmd op=0, data=4'b1010 → {S1,S0}=3 for 1 cycle; Q=1010; done 2 cycles after accept; cmd_ready back 1 cycle later.
- Shift left with fill: Q=0000, op=1, N=3, fill=1 → Q sequence 0001, 0011, 0111; {S1,S0}=1 for exactly 3 cycles; then done.
- Rotate left: Q=1000, op=3, N=5 → Q sequence 0001, 0010, 0100, 1000, 0001; final Q=0001.
- Zero count and busy ignore: op=2, N=0 → done 1 cycle after accept, Q unchanged. A second cmd_valid asserted during busy is not accepted, and cmd_ready stays 0.
- Reset mid-RUN: op=1, N=7, _MR low after step 2 → outputs zero immediately, Q=0, state IDLE, no done pulse.
- Abort (with SHREG_SEQ_ABORT_EN defined): op=2, N=6, fill=0, Q=1111, abort after step 2 → Q=0011; done=aborted=1 for 1 cycle.
